// File: rtl/arbitro_suma_productos_pkg.sv
// Shared types and widths for the round-robin sum-of-products arbiter.
package arbitro_suma_productos_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        EVALUA,
        ENTREGA
    } estadoT;

    localparam int OPERANDO_W = 4;
    localparam int CONTADOR_W = 16;

endpackage

// File: rtl/suma_productos_nucleo.sv
// Combinational 4-input sum-of-products evaluator: E[3]&E[2] | E[1]&E[0].
module suma_productos_nucleo
    import arbitro_suma_productos_pkg::*;
(
    input  logic [OPERANDO_W-1:0] Operando,
    output logic                  Valor
);

    assign Valor = (Operando[3] & Operando[2]) | (Operando[1] & Operando[0]);

endmodule

// File: rtl/arbitro_suma_productos.sv
// Round-robin arbiter sharing one sum-of-products evaluator among requesters.
// Optional delivery statistics enabled by defining SUMA_PRODUCTOS_ESTADISTICAS_EN.
module arbitro_suma_productos
    import arbitro_suma_productos_pkg::*;
#(
    parameter int NUM_SOLICITANTES = 4,
    parameter int ID_W             = $clog2(NUM_SOLICITANTES)
) (
    input  logic                                  Reloj,
    input  logic                                  Reset_n,
    input  logic [NUM_SOLICITANTES-1:0]           Solicitud,
    input  logic [OPERANDO_W*NUM_SOLICITANTES-1:0] Entrada,
    output logic [NUM_SOLICITANTES-1:0]           Concesion,
    output logic                                  Resultado_Valido,
    input  logic                                  Resultado_Listo,
    output logic                                  Resultado,
    output logic [ID_W-1:0]                       Resultado_Id
`ifdef SUMA_PRODUCTOS_ESTADISTICAS_EN
    ,
    output logic [CONTADOR_W-1:0]                 Contador_Entregas,
    output logic [CONTADOR_W-1:0]                 Contador_Unos
`endif
);

    estadoT                estado, estadoSig;
    logic [ID_W-1:0]       ultimo, ganador, idCapturado;
    logic                  hayGanador, puedeConceder, concede;
    logic [OPERANDO_W-1:0] operando;
    logic                  evaluado;

    // Search starts just after the last winner and wraps around.
    always_comb begin
        int idx;
        idx        = 0;
        ganador    = '0;
        hayGanador = 1'b0;
        for (int k = 1; k <= NUM_SOLICITANTES; k++) begin
            idx = (int'(ultimo) + k) % NUM_SOLICITANTES;
            if (!hayGanador && Solicitud[ID_W'(idx)]) begin
                hayGanador = 1'b1;
                ganador    = ID_W'(idx);
            end
        end
    end

    assign puedeConceder = (estado == REPOSO) || (estado == ENTREGA && Resultado_Listo);
    assign concede       = puedeConceder && hayGanador;

    always_comb begin
        Concesion = '0;
        if (concede) Concesion[ganador] = 1'b1;
    end

    always_comb begin
        estadoSig = estado;
        case (estado)
            REPOSO:  if (concede) estadoSig = EVALUA;
            EVALUA:  estadoSig = ENTREGA;
            ENTREGA: if (Resultado_Listo) estadoSig = concede ? EVALUA : REPOSO;
            default: estadoSig = REPOSO;
        endcase
    end

    suma_productos_nucleo uNucleo (
        .Operando (operando),
        .Valor    (evaluado)
    );

    // Pointer starts at the last index so requester 0 wins first after reset.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado           <= REPOSO;
            ultimo           <= ID_W'(NUM_SOLICITANTES - 1);
            operando         <= '0;
            idCapturado      <= '0;
            Resultado        <= 1'b0;
            Resultado_Id     <= '0;
            Resultado_Valido <= 1'b0;
        end else begin
            estado <= estadoSig;
            if (concede) begin
                operando    <= Entrada[ganador*OPERANDO_W +: OPERANDO_W];
                idCapturado <= ganador;
                ultimo      <= ganador;
            end
            if (estado == EVALUA) begin
                Resultado        <= evaluado;
                Resultado_Id     <= idCapturado;
                Resultado_Valido <= 1'b1;
            end else if (estado == ENTREGA && Resultado_Listo) begin
                Resultado_Valido <= 1'b0;
            end
        end
    end

`ifdef SUMA_PRODUCTOS_ESTADISTICAS_EN
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            Contador_Entregas <= '0;
            Contador_Unos     <= '0;
        end else if (Resultado_Valido && Resultado_Listo) begin
            Contador_Entregas <= Contador_Entregas + 1'b1;
            if (Resultado) Contador_Unos <= Contador_Unos + 1'b1;
        end
    end
`endif

endmodule

// File: doc/arbitro_suma_productos.md
# arbitro_suma_productos

Controller that shares a single 4-input sum-of-products evaluator (Resultado = E[3]&E[2] | E[1]&E[0]) among NUM_SOLICITANTES requesters. It arbitrates round-robin, captures the winner's 4-bit operand, sequences evaluation through a registered stage and holds the result under a valid/ready handshake until it is consumed. It sits between the requesting control units and the shared combinational evaluator in the ld2ud datapath.

## Interface
- NUM_SOLICITANTES, 4: number of requesters (2..8).
- ID_W, $clog2(NUM_SOLICITANTES): width of requester index.
- Reloj  input  1  clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Solicitud  input  NUM_SOLICITANTES  per-requester request, level; held until granted.
- Entrada  input  4*NUM_SOLICITANTES  operand of requester i at [4i+3:4i]; stable while Solicitud[i]=1.
- Concesion  output  NUM_SOLICITANTES  one-hot grant; operand captured on the same rising edge.
- Resultado_Valido  output  1  result held and valid.
- Resultado_Listo  input  1  consumer accepts result.
- Resultado  output  1  sum-of-products value.
- Resultado_Id  output  ID_W  index of requester that produced Resultado.
- Contador_Entregas  output  16  (only with SUMA_PRODUCTOS_ESTADISTICAS_EN) delivered results.
- Contador_Unos  output  16  (only with SUMA_PRODUCTOS_ESTADISTICAS_EN) delivered results equal to 1.

## Operation
- FSM states: REPOSO, EVALUA, ENTREGA. Reset state REPOSO.
- REPOSO: if any Solicitud, Concesion[w]=1 combinationally for winner w; on edge operand and w captured, go EVALUA. Otherwise stay.
- EVALUA: on edge evaluator output on captured operand registered into Resultado, Resultado_Id=w; go ENTREGA. Always exactly one cycle.
- ENTREGA: Resultado_Valido=1. If Resultado_Listo=0 stay, outputs stable, Concesion=0. If Resultado_Listo=1: transfer completes on edge; if any Solicitud in same cycle, grant new winner (Concesion asserted this cycle) and go EVALUA, else go REPOSO.
- Grants issued only in REPOSO, or ENTREGA with Resultado_Listo=1; never in EVALUA.
- Round-robin: search starts at index (last winner + 1) mod NUM_SOLICITANTES, ascending with wrap. After reset, pointer so requester 0 has highest priority. Pointer updates only on a grant.
- Solicitud[i] withdrawn before grant: no effect, no grant to i.
- Reset_n low at any time: immediate return to REPOSO, in-flight transaction discarded, counters cleared.

## Timing
- Reset values: Concesion=0, Resultado_Valido=0, Resultado=0, Resultado_Id=0, counters=0.
- Latency: grant at edge k, Resultado_Valido high from edge k+1 (after EVALUA cycle) i.e. visible in cycle k+2... precisely: capture edge k, result register edge k+1, Resultado_Valido=1 in cycle after edge k+1.
- Peak throughput: one result per 2 cycles with Resultado_Listo held high.
- Concesion is combinational from Solicitud, state and pointer; all other outputs registered.

## Configuration
- SUMA_PRODUCTOS_ESTADISTICAS_EN defined: Contador_Entregas increments on every completed transfer (Valido & Listo); Contador_Unos additionally when Resultado=1. Both 16-bit, wrap 0xFFFF->0x0000.
- Not defined: both ports and counters absent; no other behaviour change.

## Structure
- Package arbitro_suma_productos_pkg: FSM state enum (REPOSO, EVALUA, ENTREGA), OPERANDO_W=4, CONTADOR_W=16.
- Sub-module suma_productos_nucleo: pure combinational 4-bit -> 1-bit evaluator (E[3]&E[2] | E[1]&E[0]), instantiated once.

## Test plan
- Reset, Solicitud=4'b0100, Entrada[11:8]=4'b0011, Listo=1 -> Concesion=4'b0100 one cycle, Resultado=1, Resultado_Id=2, Valido one cycle.
- Solicitud=4'b1111 held, operands 0x0,0x3,0xC,0x5, Listo=1 -> grants 0,1,2,3,0 in order, results 0,1,1,0, one per 2 cycles.
- Result pending, Listo=0 for 5 cycles with Solicitud=4'b0001 -> Valido, Resultado, Id stable, Concesion=0 throughout; grant in cycle Listo rises.
- Reset_n pulsed low during EVALUA -> Valido stays 0, state REPOSO, next grant goes to requester 0.
- Exhaustive: single requester sweeps Entrada 0x0..0xF -> Resultado=1 exactly for 0x3,0x7,0xB,0xC,0xD,0xE,0xF.
- With SUMA_PRODUCTOS_ESTADISTICAS_EN, sweep above -> Contador_Entregas=16, Contador_Unos=7; preload 0xFFFF path wraps to 0x0000.
